// File: rtl/posit_mac_seq.sv
// Sequencer for the posit MAC pipeline: admits len operand pairs, drives stage valids, buffers the result.
// Latency: last issue at t -> vld_d[0] at t+1, result strobe expected at t+DEPTH+1, out_vld_o at t+DEPTH+2 (+1 per stall).
// Backpressure: stall_i freezes vld_d and blocks issue; out_rdy_i low holds the result in HOLD indefinitely.
module posit_mac_seq #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 12,
  parameter int LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rstn,
  input  logic             start_i,
  input  logic [LEN_W-1:0] cfg_len_i,
  input  logic             abort_i,
  input  logic             stall_i,
  input  logic             in_vld_i,
  output logic             in_rdy_o,
  output logic             acc_clr_o,
  output logic             acc_last_o,
  output logic [DEPTH-1:0] vld_d,
  output logic             acc_rdy,
  input  logic             res_vld_i,
  input  logic [WIDTH-1:0] res_i,
  output logic             out_vld_o,
  input  logic             out_rdy_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, HOLD} state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, cnt_q;
  logic             issue, cnt_last, start_ok, res_take, hs;

  assign cnt_last  = (cnt_q == len_q - LEN_ONE);
  assign acc_rdy   = ~stall_i;
  assign out_vld_o = (state_q == HOLD);
  assign busy_o    = (state_q != IDLE);

  // Next-state and issue qualification; abort overrides every other action.
  always_comb begin
    state_d    = state_q;
    in_rdy_o   = 1'b0;
    issue      = 1'b0;
    acc_clr_o  = 1'b0;
    acc_last_o = 1'b0;
    start_ok   = 1'b0;
    res_take   = 1'b0;
    hs         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          start_ok = 1'b1;
          state_d  = FEED;
        end
      end
      FEED: begin
        in_rdy_o   = ~stall_i;
        issue      = in_vld_i & ~stall_i;
        acc_clr_o  = issue & (cnt_q == '0);
        acc_last_o = issue & cnt_last;
        if (issue && cnt_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (res_vld_i) begin
          res_take = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (out_rdy_i) begin
          hs      = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_i) begin
      state_d    = IDLE;
      in_rdy_o   = 1'b0;
      issue      = 1'b0;
      acc_clr_o  = 1'b0;
      acc_last_o = 1'b0;
      start_ok   = 1'b0;
      res_take   = 1'b0;
      hs         = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Job length latch and issue counter; a zero length runs as a single product.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      len_q <= '0;
      cnt_q <= '0;
    end else if (abort_i) begin
      cnt_q <= '0;
    end else if (start_ok) begin
      len_q <= (cfg_len_i == '0) ? LEN_ONE : cfg_len_i;
      cnt_q <= '0;
    end else if (issue) begin
      cnt_q <= cnt_q + LEN_ONE;
    end
  end

  // Stage valid shift vector; frozen during stall, flushed on abort.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn)        vld_d <= '0;
    else if (abort_i) vld_d <= '0;
    else if (acc_rdy) vld_d <= {vld_d[DEPTH-2:0], issue};
  end

  // Result capture; data stays stable while waiting in HOLD.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn)         out_data_o <= '0;
    else if (res_take) out_data_o <= res_i;
  end

  // Completion pulse one cycle after the output handshake.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) done_o <= 1'b0;
    else       done_o <= hs;
  end

  // Sticky error for unexpected result strobes; a fresh job clears it unless a strobe arrives that same cycle.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn)                             err_o <= 1'b0;
    else if (res_vld_i && state_q != DRAIN) err_o <= 1'b1;
    else if (start_ok)                     err_o <= 1'b0;
  end

endmodule

// File: doc/posit_mac_seq.md
# posit_mac_seq

Sequencing controller for the posit multiply-accumulate pipeline. It accepts a dot-product job (start plus length) and admits exactly `len` operand pairs into the datapath. It generates the per-stage valid shift vector `vld_d` and the global pipeline enable `acc_rdy` consumed by the MAC and encoder stages, then drains the pipeline and captures the encoded posit result. The result is held in a one-entry output buffer with a valid/ready handshake toward the downstream consumer.

## Interface
- `WIDTH`, 8, posit word width of the final result.
- `DEPTH`, 12, pipeline depth; width of `vld_d`, bit `DEPTH-1` = encoder output stage.
- `LEN_W`, 8, width of the job length field.

- `clk_i`  in  1  clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  job start pulse; sampled only in IDLE.
- `cfg_len_i`  in  LEN_W  products per job; 0 is treated as 1.
- `abort_i`  in  1  synchronous job abort.
- `stall_i`  in  1  pipeline-wide stall request.
- `in_vld_i`  in  1  operand pair valid.
- `in_rdy_o`  out  1  operand pair accepted when `in_vld_i & in_rdy_o`.
- `acc_clr_o`  out  1  qualifies issue: first product of job (load, not add).
- `acc_last_o`  out  1  qualifies issue: last product of job.
- `vld_d`  out  DEPTH  stage valid vector to datapath.
- `acc_rdy`  out  1  pipeline enable to datapath (= `~stall_i`).
- `res_vld_i`  in  1  encoder result strobe (one-cycle pulse).
- `res_i`  in  WIDTH  encoder result word.
- `out_vld_o` / `out_rdy_i`  out/in  1  result handshake.
- `out_data_o`  out  WIDTH  buffered result.
- `busy_o`  out  1  state != IDLE.
- `done_o`  out  1  one-cycle pulse after result handshake completes.
- `err_o`  out  1  sticky: `res_vld_i` seen outside DRAIN; cleared on accepted `start_i`.

## Operation
- States: IDLE, FEED, DRAIN, HOLD.
- IDLE: on `start_i`, latch `len = (cfg_len_i==0) ? 1 : cfg_len_i`, clear `cnt` and `err_o`, go to FEED.
- FEED: `in_rdy_o = ~stall_i`. `issue = in_vld_i & in_rdy_o`. `acc_clr_o = issue & (cnt==0)`; `acc_last_o = issue & (cnt==len-1)`. On issue, `cnt` increments. On the last issue, go to DRAIN.
- Pipeline vector: when `acc_rdy`, `vld_d <= {vld_d[DEPTH-2:0], issue}`; when stalled, hold. Bubbles (no issue in FEED) shift in 0.
- DRAIN: no issue. On `res_vld_i`, capture `res_i` into `out_data_o`, set `out_vld_o`, go to HOLD.
- HOLD: `out_vld_o` stays 1 and `out_data_o` stays stable until `out_rdy_i`. Then clear `out_vld_o`, pulse `done_o` the next cycle, go to IDLE.
- `abort_i` (any state, priority over everything but reset): `vld_d <= 0`, `cnt <= 0`, `out_vld_o <= 0`, go to IDLE. No `done_o`.
- `start_i` outside IDLE is ignored. `res_vld_i` outside DRAIN is ignored and sets `err_o`.
- `cnt` is LEN_W bits and never wraps: the FEED→DRAIN exit fires at `cnt==len-1`.

## Timing
- Reset values: `vld_d=0`, `in_rdy_o=0`, `acc_clr_o=0`, `acc_last_o=0`, `out_vld_o=0`, `out_data_o=0`, `done_o=0`, `busy_o=0`, `err_o=0`, state IDLE. `acc_rdy` follows `~stall_i`.
- Start accepted at cycle 0; `in_rdy_o` first high at cycle 1.
- Last issue at cycle t, no stalls:
  - `vld_d[0]` high at t+1.
  - `vld_d` equals only bit `DEPTH-1` set at t+DEPTH.
  - `res_vld_i` at t+DEPTH+1.
  - `out_vld_o` at t+DEPTH+2.
- Each stalled cycle adds exactly one cycle to this latency.
- `vld_d` returns to all zero one enabled cycle after its `DEPTH-1` only state; the encoder relies on this to clear.
- Handshake completes on a cycle with `out_vld_o & out_rdy_i`. `done_o` and IDLE follow one cycle later. `start_i` is accepted in that IDLE cycle at the earliest.
- A `stall_i` in the same cycle as `in_vld_i` blocks the issue; the operand must be held by the source.
- Reset mid-job: all state is cleared immediately (asynchronous); no result or `done_o`.

## Test plan
- len=4, `DEPTH=12`, no stall, `out_rdy_i=1`, start at cycle 0 → issues at cycles 1-4, `acc_clr_o` at 1, `acc_last_o` at 4, `out_vld_o` at 18 with `out_data_o=res_i`, `done_o` at 19.
- `cfg_len_i=0` → exactly one issue with `acc_clr_o` and `acc_last_o` both high.
- len=3 with `stall_i` high for cycles 2-4 → no issue while stalled, `vld_d` frozen, result 3 cycles later than the unstalled case.
- `out_rdy_i` low for 5 cycles after the result → `out_vld_o` and data held stable; `start_i` ignored; `done_o` only after the handshake.
- `abort_i` mid-DRAIN → `vld_d=0`, IDLE next cycle, no `out_vld_o` or `done_o`; a later `res_vld_i` sets `err_o`.
- `rstn` low during FEED with `in_vld_i` high → all outputs at reset values, `in_rdy_o=0` until a new start.
